// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared constants for the 64-bit timer: counter width, largest prescaler
// exponent, TDR0/TDR1 byte-lane geometry, and the byte-strobe merge helper
// used when software writes one 32-bit half of the counter.
// ----------------------------------------------------------------------------
package timer_pkg;

  localparam int CNT_W     = 64;  // counter width (only 64 supported)
  localparam int DIV_MAX   = 8;   // largest legal prescaler exponent
  localparam int DIV_CNT_W = 8;   // prescaler counter width, holds 2^DIV_MAX-1
  localparam int TDR_W     = 32;  // width of one TDR register (half counter)
  localparam int LANE_W    = 8;   // one APB byte lane
  localparam int TDR_LANES = 4;   // byte lanes per TDR register

  // Replace every byte of old_val whose strobe bit is set with new_val's byte.
  function automatic logic [TDR_W-1:0] byte_merge(
    input logic [TDR_W-1:0]     old_val,
    input logic [TDR_W-1:0]     new_val,
    input logic [TDR_LANES-1:0] strb
  );
    logic [TDR_W-1:0] res;
    res = old_val;
    for (int i = 0; i < TDR_LANES; i++) begin
      if (strb[i]) begin
        res[i*LANE_W +: LANE_W] = new_val[i*LANE_W +: LANE_W];
      end else begin
        res[i*LANE_W +: LANE_W] = old_val[i*LANE_W +: LANE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_div.sv
// ----------------------------------------------------------------------------
// timer_div
// Power-of-two prescaler. Emits a one-cycle tick every 2^div_val active
// cycles (every active cycle when the divider is bypassed or div_val=0).
// Exponents above DIV_MAX saturate to DIV_MAX.
// Ports:
//   clk, rst_n   block clock / async active-low reset
//   timer_en     counting enable; low clears the prescaler phase
//   active       timer_en & ~halt_req; low (while enabled) freezes the phase
//   div_en       prescaler enable; low clears the phase and bypasses division
//   div_val      prescaler exponent
//   tick         combinational count-advance strobe for this cycle
// ----------------------------------------------------------------------------
module timer_div
  import timer_pkg::*;
#(
  parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       timer_en,
  input  logic       active,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [3:0]           w_exp;
  logic [DIV_CNT_W-1:0] w_term;
  logic                 w_tick;
  logic [DIV_CNT_W-1:0] r_div_cnt;
  logic [DIV_CNT_W-1:0] w_div_cnt_nxt;

  // Saturated exponent, terminal count 2^exp-1 and the tick decode.
  always_comb begin
    w_exp = div_val;
    if (div_val > 4'(DIV_MAX)) begin
      w_exp = 4'(DIV_MAX);
    end else begin
      w_exp = div_val;
    end
    // A right shift of all-ones gives 2^exp-1 without a wider intermediate.
    w_term = {DIV_CNT_W{1'b1}} >> (4'(DIV_CNT_W) - w_exp);
    w_tick = active & (~div_en | (w_exp == 4'd0) | (r_div_cnt == w_term));
  end

  // Prescaler phase: cleared when disabled, frozen while halted, wraps on tick.
  always_comb begin
    w_div_cnt_nxt = r_div_cnt;
    if (!timer_en || !div_en) begin
      w_div_cnt_nxt = {DIV_CNT_W{1'b0}};
    end else if (!active) begin
      w_div_cnt_nxt = r_div_cnt;
    end else if (w_tick) begin
      w_div_cnt_nxt = {DIV_CNT_W{1'b0}};
    end else begin
      w_div_cnt_nxt = r_div_cnt + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= {DIV_CNT_W{1'b0}};
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
    end
  end

  assign tick = w_tick;

endmodule

// File: rtl/timer_counter.sv
// ----------------------------------------------------------------------------
// timer_counter
// 64-bit free-running timer with power-of-two prescaler, debug halt and
// byte-strobed software writes of each 32-bit half (TDR0 = low, TDR1 = high).
// Update priority each cycle: timer_en_neg clear, then TDR write, then tick.
// A tick that loses to a higher-priority event is dropped.
// Ports:
//   clk, rst_n              block clock / async active-low reset
//   timer_en, timer_en_neg  counting enable and its falling-edge pulse
//   div_en, div_val         prescaler enable / exponent
//   halt_req                debug halt, freezes counting and prescaler
//   tdr0_wr_sel/tdr1_wr_sel APB write to low / high counter half
//   wdata, pstrb            APB write data and byte strobes
//   cnt                     registered counter value
//   cnt_en                  registered pulse, high the cycle after an increment
// ----------------------------------------------------------------------------
module timer_counter #(
  parameter int CNT_W   = timer_pkg::CNT_W,
  parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             halt_req,
  input  logic             timer_en_neg,
  input  logic             tdr0_wr_sel,
  input  logic             tdr1_wr_sel,
  input  logic [31:0]      wdata,
  input  logic [3:0]       pstrb,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_en
);

  import timer_pkg::*;

  logic             w_active;
  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_en_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_en;

  assign w_active = timer_en & ~halt_req;

  timer_div #(
    .DIV_MAX (DIV_MAX)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .timer_en (timer_en),
    .active   (w_active),
    .div_en   (div_en),
    .div_val  (div_val),
    .tick     (w_tick)
  );

  // Priority mux: clear, then software write, then prescaled increment.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_cnt_en_nxt = 1'b0;
    if (timer_en_neg) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (tdr0_wr_sel) begin
      w_cnt_nxt[TDR_W-1:0] = byte_merge(r_cnt[TDR_W-1:0], wdata, pstrb);
    end else if (tdr1_wr_sel) begin
      w_cnt_nxt[CNT_W-1:TDR_W] = byte_merge(r_cnt[CNT_W-1:TDR_W], wdata, pstrb);
    end else if (w_tick) begin
      // Natural modulo-2^64 wrap, no overflow flag.
      w_cnt_nxt    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      w_cnt_en_nxt = 1'b1;
    end else begin
      w_cnt_nxt    = r_cnt;
      w_cnt_en_nxt = 1'b0;
    end
  end

  // Counter and increment-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_cnt_en <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_cnt_en <= w_cnt_en_nxt;
    end
  end

  assign cnt    = r_cnt;
  assign cnt_en = r_cnt_en;

endmodule

// File: tb/tb_timer_counter.sv
// ----------------------------------------------------------------------------
// tb_timer_counter
// Self-checking bench for timer_counter. A cycle model predicts cnt/cnt_en
// for every clock and queues the prediction; each test task pops and
// compares after the edge, and adds fixed-value checks for its scenario.
// ----------------------------------------------------------------------------
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        timer_en = 1'b0;
  logic        div_en = 1'b0;
  logic [3:0]  div_val = 4'd0;
  logic        halt_req = 1'b0;
  logic        timer_en_neg = 1'b0;
  logic        tdr0_wr_sel = 1'b0;
  logic        tdr1_wr_sel = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  pstrb = 4'd0;
  logic [63:0] cnt;
  logic        cnt_en;

  typedef struct {
    logic [63:0] cnt;
    logic        en;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] m_cnt = 64'd0;
  int          m_phase = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  timer_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .timer_en     (timer_en),
    .div_en       (div_en),
    .div_val      (div_val),
    .halt_req     (halt_req),
    .timer_en_neg (timer_en_neg),
    .tdr0_wr_sel  (tdr0_wr_sel),
    .tdr1_wr_sel  (tdr1_wr_sel),
    .wdata        (wdata),
    .pstrb        (pstrb),
    .cnt          (cnt),
    .cnt_en       (cnt_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Predict the effect of the current inputs, queue it, then clock once.
  task automatic step();
    exp_t e;
    int   n;
    logic tk;
    n  = (div_val > 4'd8) ? 8 : int'(div_val);
    tk = timer_en && !halt_req && (!div_en || n == 0 || m_phase == (1 << n) - 1);
    if (!timer_en || !div_en) m_phase = 0;
    else if (halt_req)        m_phase = m_phase;
    else if (tk)              m_phase = 0;
    else                      m_phase = m_phase + 1;
    e.en = 1'b0;
    if (timer_en_neg)     m_cnt = 64'd0;
    else if (tdr0_wr_sel) m_cnt[31:0]  = mrg(m_cnt[31:0], wdata, pstrb);
    else if (tdr1_wr_sel) m_cnt[63:32] = mrg(m_cnt[63:32], wdata, pstrb);
    else if (tk) begin
      m_cnt = m_cnt + 64'd1;
      e.en  = 1'b1;
    end
    e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt   = 64'd0;
    m_phase = 0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (cnt !== 64'd0 || cnt_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: cnt=%h cnt_en=%b, expected 0/0", cnt, cnt_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== e.cnt || cnt_en !== e.en) begin
      n_err++;
      $display("FAIL reset_idle: cnt=%h en=%b, expected %h/%b", cnt, cnt_en, e.cnt, e.en);
    end
  endtask

  task automatic clear_cnt(input string tag);
    exp_t e;
    timer_en = 1'b0; timer_en_neg = 1'b1; halt_req = 1'b0;
    step();
    timer_en_neg = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== 64'd0 || cnt !== e.cnt || cnt_en !== e.en) begin
      n_err++;
      $display("FAIL %s_clear: cnt=%h en=%b, expected 0/%b", tag, cnt, cnt_en, e.en);
    end
  endtask

  task automatic test_free_run();
    exp_t e;
    int   highs = 0;
    timer_en = 1'b1; div_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en) begin
        n_err++;
        $display("FAIL free_run[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, e.cnt, e.en);
      end
      if (cnt_en === 1'b1) highs++;
    end
    n_cmp++;
    if (cnt !== 64'd10 || highs != 10) begin
      n_err++;
      $display("FAIL free_run_total: cnt=%0d highs=%0d, expected 10/10", cnt, highs);
    end
    clear_cnt("free_run");
  endtask

  task automatic test_prescale();
    exp_t e;
    int   pulses = 0;
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd2;
    for (int i = 0; i < 16; i++) begin
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt_en !== ((i % 4) == 3)) begin
        n_err++;
        $display("FAIL prescale2[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, e.cnt, e.en);
      end
      if (cnt_en === 1'b1) pulses++;
    end
    n_cmp++;
    if (cnt !== 64'd4 || pulses != 4) begin
      n_err++;
      $display("FAIL prescale2_total: cnt=%0d pulses=%0d, expected 4/4", cnt, pulses);
    end
    clear_cnt("prescale2");
    // Exponent 13 saturates to 8: first increment on the 256th active cycle.
    timer_en = 1'b1; div_val = 4'd13;
    for (int i = 0; i < 256; i++) begin
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt !== ((i == 255) ? 64'd1 : 64'd0)) begin
        n_err++;
        $display("FAIL prescale_sat[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, e.cnt, e.en);
      end
    end
    clear_cnt("prescale_sat");
    div_val = 4'd0;
  endtask

  task automatic test_wrap();
    exp_t        e;
    logic [63:0] want[3];
    want[0] = 64'hFFFF_FFFF_FFFF_FFFF; want[1] = 64'd0; want[2] = 64'd1;
    timer_en = 1'b0; pstrb = 4'hF;
    tdr1_wr_sel = 1'b1; wdata = 32'hFFFF_FFFF;
    step();
    tdr1_wr_sel = 1'b0;
    tdr0_wr_sel = 1'b1; wdata = 32'hFFFF_FFFE;
    step();
    tdr0_wr_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (i == 1 && (cnt !== e.cnt || cnt !== 64'hFFFF_FFFF_FFFF_FFFE)) begin
        n_err++;
        $display("FAIL wrap_load: cnt=%h, expected %h", cnt, e.cnt);
      end
    end
    timer_en = 1'b1; div_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt !== want[i]) begin
        n_err++;
        $display("FAIL wrap[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, want[i], e.en);
      end
    end
    clear_cnt("wrap");
  endtask

  task automatic test_strobe();
    exp_t e;
    timer_en = 1'b0; tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'h1234_5678;
    step();
    e = sb_q.pop_front();
    // Partial write with a tick in the same cycle: the tick is dropped.
    timer_en = 1'b1; div_en = 1'b0; pstrb = 4'b0010; wdata = 32'h0000_AB00;
    step();
    e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== e.cnt || cnt_en !== e.en || cnt !== 64'h1234_AB78 || cnt_en !== 1'b0) begin
      n_err++;
      $display("FAIL strobe_tdr0: cnt=%h en=%b, expected 00000000_1234ab78/0", cnt, cnt_en);
    end
    tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b1; pstrb = 4'b1001; wdata = 32'hA1B2_C3D4;
    step();
    e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== e.cnt || cnt_en !== e.en || cnt !== 64'hA100_00D4_1234_AB78) begin
      n_err++;
      $display("FAIL strobe_tdr1: cnt=%h en=%b, expected a10000d4_1234ab78/0", cnt, cnt_en);
    end
    tdr1_wr_sel = 1'b0;
    step();
    e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== e.cnt || cnt_en !== e.en || cnt !== 64'hA100_00D4_1234_AB79) begin
      n_err++;
      $display("FAIL strobe_resume: cnt=%h en=%b, expected a10000d4_1234ab79/1", cnt, cnt_en);
    end
    clear_cnt("strobe");
  endtask

  task automatic test_halt();
    exp_t e;
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd3;
    for (int i = 0; i < 21; i++) begin
      halt_req = (i >= 5 && i < 10);
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt_en !== (i == 12 || i == 20)) begin
        n_err++;
        $display("FAIL halt[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, e.cnt, e.en);
      end
    end
    halt_req = 1'b0;
    n_cmp++;
    if (cnt !== 64'd2) begin
      n_err++;
      $display("FAIL halt_total: cnt=%0d, expected 2", cnt);
    end
    clear_cnt("halt");
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [63:0] want[4];
    want[0] = 64'd1; want[1] = 64'd0; want[2] = 64'h77; want[3] = 64'h78;
    for (int i = 0; i < 4; i++) begin
      timer_en = (i != 1); div_en = 1'b0; timer_en_neg = (i == 1);
      tdr0_wr_sel = (i == 1 || i == 2); halt_req = (i == 2);
      wdata = (i == 1) ? 32'hDEAD_BEEF : 32'h0000_0077;
      pstrb = (i == 1) ? 4'hF : 4'b0001;
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt !== want[i]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, want[i], e.en);
      end
    end
    timer_en_neg = 1'b0; tdr0_wr_sel = 1'b0; halt_req = 1'b0;
    clear_cnt("back_to_back");
  endtask

  task automatic test_reset_mid();
    exp_t e;
    timer_en = 1'b0; tdr0_wr_sel = 1'b1; pstrb = 4'hF; wdata = 32'h0000_0053;
    step();
    tdr0_wr_sel = 1'b0;
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd1;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 6; i++) e = sb_q.pop_front();
    n_cmp++;
    if (cnt !== e.cnt || cnt !== 64'h55) begin
      n_err++;
      $display("FAIL reset_mid_pre: cnt=%h, expected 55", cnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cnt !== 64'd0 || cnt_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_async: cnt=%h en=%b, expected 0/0", cnt, cnt_en);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      e = sb_q.pop_front();
      n_cmp++;
      if (cnt !== e.cnt || cnt_en !== e.en || cnt_en !== (i == 1 || i == 3)) begin
        n_err++;
        $display("FAIL reset_phase[%0d]: cnt=%h en=%b, expected %h/%b", i, cnt, cnt_en, e.cnt, e.en);
      end
    end
    timer_en = 1'b0; div_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_prescale();
    test_wrap();
    test_strobe();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
